// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM port arbiter.
// The optional ownership feature is enabled with the RAM_ARB_LOCK_EN macro (see ram_port_arbiter).
package ram_arb_pkg;

  localparam int unsigned MAX_REQ = 32;
  localparam int unsigned PICK_IW = 5;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic               found;
    logic [PICK_IW-1:0] idx;
  } rr_pick_t;

  // Requester index width; never below one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

  // First set request scanning ptr+1 upward with wrap-around back to ptr
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input int unsigned         nreq,
                                       input int unsigned         ptr);
    rr_pick_t    r;
    int unsigned i;
    r = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      if (!r.found && (k <= nreq)) begin
        i = ptr + k;
        if (i >= nreq) i = i - nreq;
        if (req[PICK_IW'(i)]) begin
          r.found = 1'b1;
          r.idx   = PICK_IW'(i);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_arb_rr_picker.sv
// Combinational rotate-priority encoder: winner index after ptr, plus any-request flag.
module ram_arb_rr_picker
  import ram_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx_c,
  output logic            any_c
);

  rr_pick_t pick;

  // Rotate-priority search over the request vector
  always_comb begin
    pick  = rr_pick(MAX_REQ'(req), NREQ, 32'(ptr));
    idx_c = IW'(pick.idx);
    any_c = pick.found;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NREQ requesters.
// Define RAM_ARB_LOCK_EN to let a requester hold ownership across accesses (atomic RMW).
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            we,
  input  logic [NREQ*ADDR_WIDTH-1:0] addr,
  input  logic [NREQ*DATA_WIDTH-1:0] wdata,
  input  logic [NREQ-1:0]            lock,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       mem_wr,
  output logic                       mem_rd,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  output logic                       busy
);

  localparam int unsigned IW = idx_width(NREQ);

  arb_state_t            state_q, state_d;
  logic [IW-1:0]         win_q, win_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic                  we_q, we_d;
  logic [NREQ-1:0]       gnt_d, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_d, mem_wdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic                  mem_wr_d, mem_rd_d, busy_d;
  logic [NREQ-1:0]       eff_req_c;
  logic [IW-1:0]         pick_idx_c;
  logic                  pick_any_c;

  ram_arb_rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req   (eff_req_c),
    .ptr   (ptr_q),
    .idx_c (pick_idx_c),
    .any_c (pick_any_c)
  );

`ifdef RAM_ARB_LOCK_EN
  logic          own_v_q;
  logic [IW-1:0] own_q;
  logic          lock_q;

  // Ownership: taken or dropped at each grant, released when the owner stops requesting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_v_q <= 1'b0;
      own_q   <= '0;
      lock_q  <= 1'b0;
    end else begin
      case (state_q)
        ARB: begin
          if (own_v_q && !req[own_q]) own_v_q <= 1'b0;
          if (pick_any_c) lock_q <= lock[pick_idx_c];
        end
        ACCESS: begin
          own_v_q <= lock_q;
          own_q   <= win_q;
        end
        default: ;
      endcase
    end
  end

  // While owned and still requesting, only the owner is eligible
  always_comb begin
    eff_req_c = req;
    if (own_v_q && req[own_q]) eff_req_c = NREQ'(1) << own_q;
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign eff_req_c   = req;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    we_d        = we_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata;
    mem_wr_d    = 1'b0;
    mem_rd_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state_q)
      ARB: begin
        if (pick_any_c) begin
          win_d      = pick_idx_c;
          we_d       = we[pick_idx_c];
          gnt_d      = NREQ'(1) << pick_idx_c;
          mem_wr_d   = we[pick_idx_c];
          mem_rd_d   = ~we[pick_idx_c];
          mem_addr_d = addr[pick_idx_c*ADDR_WIDTH +: ADDR_WIDTH];
          if (we[pick_idx_c]) mem_wdata_d = wdata[pick_idx_c*DATA_WIDTH +: DATA_WIDTH];
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        ptr_d   = win_q;
        state_d = we_q ? ARB : RDWAIT;
      end
      RDWAIT: begin
        rdata_d  = mem_rdata;
        rvalid_d = NREQ'(1) << win_q;
        state_d  = ARB;
      end
      default: state_d = ARB;
    endcase
    busy_d = (state_d != ARB);
  end

  // State, capture and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB;
      win_q     <= '0;
      we_q      <= 1'b0;
      ptr_q     <= IW'(NREQ - 1);
      gnt       <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      mem_wr    <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      we_q      <= we_d;
      ptr_q     <= ptr_d;
      gnt       <= gnt_d;
      rvalid    <= rvalid_d;
      rdata     <= rdata_d;
      mem_wr    <= mem_wr_d;
      mem_rd    <= mem_rd_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      busy      <= busy_d;
    end
  end

endmodule
